// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared types and constants for the gate self-test sequencer
package gate_test_pkg;

  localparam int NUM_VEC = 4;
  localparam int NUM_OUT = 5;
  localparam logic [NUM_VEC*NUM_OUT-1:0] DEFAULT_EXP_TABLE = 20'h1B9D8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_FINISH
  } state_e;

  // Expected {Out_4..Out_0} for input vector v.
  function automatic logic [NUM_OUT-1:0] exp_vec(input logic [NUM_VEC*NUM_OUT-1:0] tbl,
                                                 input logic [1:0] v);
    return tbl[NUM_OUT*v +: NUM_OUT];
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// rtl/gate_test_sequencer_if.sv - control, stimulus and result signals of the gate self-test
interface gate_test_sequencer_if;
  import gate_test_pkg::*;

  logic               Start;
  logic               Abort;
  logic [NUM_OUT-1:0] Dut_Out;
  logic               Inp_1;
  logic               Inp_2;
  logic               Busy;
  logic               Done;
  logic               Pass;
  logic [NUM_VEC-1:0] Fail_Mask;
  logic [2:0]         Err_Count;

  modport master (
    input  Start, Abort, Dut_Out,
    output Inp_1, Inp_2, Busy, Done, Pass, Fail_Mask, Err_Count
  );

  modport slave (
    output Start, Abort, Dut_Out,
    input  Inp_1, Inp_2, Busy, Done, Pass, Fail_Mask, Err_Count
  );

endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - 4-bit loadable down-counter with zero flag for the settle wait
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - steps the gate block through all input vectors and grades its outputs
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int                           SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC*NUM_OUT-1:0]   EXP_TABLE     = DEFAULT_EXP_TABLE
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  gate_test_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [1:0]         v_q, v_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [NUM_VEC-1:0] mask_q, mask_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               tmr_load, tmr_dec, tmr_zero;

  settle_timer u_settle_timer (
    .clk      (Clk),
    .rst_n    (Rst_N),
    .load     (tmr_load),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d = ST_DRIVE;
          v_d     = 2'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          mask_d  = '0;
          cnt_d   = 3'd0;
        end
      end
      ST_DRIVE: begin
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (bus.Dut_Out != exp_vec(EXP_TABLE, v_q)) begin
          mask_d[v_q] = 1'b1;
          cnt_d       = cnt_q + 3'd1;
        end
        if (v_q == 2'd3) begin
          state_d = ST_FINISH;
        end else begin
          v_d     = v_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = ~|mask_q;
        busy_d  = 1'b0;
        v_d     = 2'd0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a Start seen in IDLE.
    if (bus.Abort) begin
      state_d  = ST_IDLE;
      v_d      = 2'd0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      mask_d   = '0;
      cnt_d    = 3'd0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= ST_IDLE;
      v_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Inp_1     = v_q[0];
  assign bus.Inp_2     = v_q[1];
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Pass      = pass_q;
  assign bus.Fail_Mask = mask_q;
  assign bus.Err_Count = cnt_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - self-checking bench for gate_test_sequencer with a gate-block model
module tb_gate_test_sequencer;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 2;
  localparam int LAT    = 4 * P + 1;

  logic Clk;
  logic Rst_N;
  int   total;
  int   bad;

  logic [4:0] flip [4];
  logic [4:0] stuck0;

  gate_test_sequencer_if bus ();

  gate_test_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .bus   (bus)
  );

  // Gate block: Out_0=AND, Out_1=OR, Out_2=XOR, Out_3=NAND, Out_4=NOR of (Inp_1, Inp_2).
  function automatic logic [4:0] gold(input logic [1:0] v);
    logic a, b;
    a = v[0];
    b = v[1];
    return {~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  assign bus.Dut_Out = (gold({bus.Inp_2, bus.Inp_1}) & ~stuck0) ^ flip[{bus.Inp_2, bus.Inp_1}];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_inp"},  {30'd0, bus.Inp_2, bus.Inp_1}, 0);
    check({tag, "_busy"}, {31'd0, bus.Busy}, 0);
    check({tag, "_done"}, {31'd0, bus.Done}, 0);
    check({tag, "_pass"}, {31'd0, bus.Pass}, 0);
    check({tag, "_mask"}, {28'd0, bus.Fail_Mask}, 0);
    check({tag, "_cnt"},  {29'd0, bus.Err_Count}, 0);
  endtask

  task automatic clear_faults();
    stuck0 = 5'd0;
    for (int v = 0; v < 4; v++) flip[v] = 5'd0;
  endtask

  // Full run from the Start edge; expected results come from the fault setup, not from the DUT.
  task automatic do_run(input string name, input bit restart);
    logic [3:0] em;
    int         ec;
    int         ev;
    logic [4:0] g;
    em = 4'd0;
    ec = 0;
    for (int v = 0; v < 4; v++) begin
      g = gold(2'(v));
      if (((g & ~stuck0) ^ flip[v]) !== g) begin
        em[v] = 1'b1;
        ec++;
      end
    end
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check({name, "_busy_e0"}, {31'd0, bus.Busy}, 1);
    check({name, "_inp_e0"},  {30'd0, bus.Inp_2, bus.Inp_1}, 0);
    for (int n = 1; n <= LAT; n++) begin
      bus.Start = restart && (n == 5 || n == 12);
      tick();
      bus.Start = 1'b0;
      if (n < LAT) begin
        ev = (n / P > 3) ? 3 : n / P;
        check($sformatf("%s_inp_e%0d", name, n), {30'd0, bus.Inp_2, bus.Inp_1}, ev);
        check($sformatf("%s_busy_e%0d", name, n), {31'd0, bus.Busy}, 1);
        check($sformatf("%s_done_e%0d", name, n), {31'd0, bus.Done}, 0);
      end else begin
        check({name, "_done"}, {31'd0, bus.Done}, 1);
        check({name, "_busy"}, {31'd0, bus.Busy}, 0);
        check({name, "_inp"},  {30'd0, bus.Inp_2, bus.Inp_1}, 0);
        check({name, "_pass"}, {31'd0, bus.Pass}, (em == 4'd0) ? 1 : 0);
        check({name, "_mask"}, {28'd0, bus.Fail_Mask}, {28'd0, em});
        check({name, "_cnt"},  {29'd0, bus.Err_Count}, ec);
      end
    end
    tick();
    check({name, "_done_hold"}, {31'd0, bus.Done}, 1);
    check({name, "_mask_hold"}, {28'd0, bus.Fail_Mask}, {28'd0, em});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    Rst_N     = 1'b0;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    clear_faults();

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      bus.Start = 1'($urandom_range(0, 1));
      bus.Abort = 1'($urandom_range(0, 1));
      flip[0]   = 5'($urandom_range(0, 31));
      tick();
      check_idle_zero($sformatf("rst%0d", i));
    end
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    clear_faults();
    Rst_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_busy%0d", i), {31'd0, bus.Busy}, 0);
    end

    do_run("clean", 1'b0);

    stuck0 = 5'b00100;
    do_run("out2_stuck0", 1'b0);
    clear_faults();

    // Abort and Start together in IDLE: results cleared, no run begins.
    bus.Abort = 1'b1;
    bus.Start = 1'b1;
    tick();
    bus.Abort = 1'b0;
    bus.Start = 1'b0;
    check_idle_zero("idle_abort");
    tick();
    check({"idle_abort_busy2"}, {31'd0, bus.Busy}, 0);

    do_run("restart_ignored", 1'b1);

    // Abort mid-run after vector 0 has already failed.
    flip[0] = 5'b00001;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    check("pre_abort_mask", {28'd0, bus.Fail_Mask}, 1);
    check("pre_abort_inp",  {30'd0, bus.Inp_2, bus.Inp_1}, 2);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check_idle_zero("abort_e9");
    tick();
    check("abort_stays_idle", {31'd0, bus.Busy}, 0);
    clear_faults();
    do_run("after_abort", 1'b0);

    // Asynchronous reset during SETTLE of vector 2.
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    check("pre_rst_inp",  {30'd0, bus.Inp_2, bus.Inp_1}, 2);
    check("pre_rst_busy", {31'd0, bus.Busy}, 1);
    Rst_N = 1'b0;
    #1;
    check_idle_zero("midrun_rst");
    tick();
    tick();
    Rst_N = 1'b1;
    tick();
    check("post_midrun_rst_busy", {31'd0, bus.Busy}, 0);
    do_run("after_rst", 1'b0);

    // Random fault patterns, occasionally with Start noise during the run.
    for (int r = 0; r < 8; r++) begin
      clear_faults();
      for (int v = 0; v < 4; v++) begin
        if ($urandom_range(0, 1) == 1) flip[v] = 5'($urandom_range(1, 31));
      end
      if ($urandom_range(0, 3) == 0) stuck0 = 5'($urandom_range(0, 31));
      do_run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
